// File: rtl/step_timer.sv
// Per-step countdown timer for the machine-selection FSM: counts each step's duration in BCD
// seconds and pulses step_done once when the step expires.
module step_timer #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned SHORT_T  = 5,
  parameter int unsigned LONG_T   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state_in,
  input  logic       pause,
  output logic       step_done,
  output logic [7:0] rem_bcd,
  output logic [1:0] step_idx,
  output logic       busy,
  output logic       cycle_done
);

  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
  localparam logic [7:0] ShortBcd = 8'((SHORT_T / 10) * 16 + (SHORT_T % 10));
  localparam logic [7:0] LongBcd  = 8'((LONG_T / 10) * 16 + (LONG_T % 10));

  typedef enum logic [1:0] {StIdle, StRun, StWaitAdv} state_e;

  state_e          r_state, w_state_next;
  logic [3:0]      r_prev_code;
  logic [PreW-1:0] r_presc;
  logic [7:0]      r_rem;
  logic [1:0]      r_idx;
  logic            r_step_done;
  logic            r_cycle_done;

  logic       w_is_short, w_is_long, w_is_step, w_change;
  logic       w_load, w_abort, w_count, w_tick, w_final;
  logic [7:0] w_dur;
  logic [1:0] w_idx;
  logic [7:0] w_rem_dec;

  assign w_is_short = (state_in >= 4'd2) && (state_in <= 4'd5);
  assign w_is_long  = (state_in >= 4'd8) && (state_in <= 4'd11);
  assign w_is_step  = w_is_short || w_is_long;
  assign w_change   = (r_prev_code != state_in);
  assign w_dur      = w_is_long ? LongBcd : ShortBcd;
  assign w_idx      = w_is_long ? state_in[1:0] : (state_in[1:0] - 2'd2);

  // Ones digit borrows from tens so neither digit ever leaves 0..9.
  assign w_rem_dec = (r_rem[3:0] == 4'd0) ? {r_rem[7:4] - 4'd1, 4'd9}
                                          : {r_rem[7:4], r_rem[3:0] - 4'd1};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_abort      = 1'b0;
    w_count      = 1'b0;
    w_tick       = 1'b0;
    w_final      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_is_step) begin
          w_load       = 1'b1;
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (w_change && w_is_step) begin
          w_load = 1'b1;
        end else if (w_change) begin
          w_abort      = 1'b1;
          w_state_next = StIdle;
        end else if (!pause) begin
          w_count = 1'b1;
          w_tick  = (r_presc == PreMax);
          if (w_tick && (r_rem == 8'h01)) begin
            w_final      = 1'b1;
            w_state_next = StWaitAdv;
          end
        end
      end
      StWaitAdv: begin
        if (w_change && w_is_step) begin
          w_load       = 1'b1;
          w_state_next = StRun;
        end else if (w_change) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy       = (r_state == StRun);
    step_done  = r_step_done;
    rem_bcd    = r_rem;
    step_idx   = r_idx;
    cycle_done = r_cycle_done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_code  <= 4'd0;
      r_presc      <= '0;
      r_rem        <= 8'h00;
      r_idx        <= 2'd0;
      r_step_done  <= 1'b0;
      r_cycle_done <= 1'b0;
    end else begin
      r_prev_code  <= state_in;
      r_step_done  <= w_final;
      r_cycle_done <= (state_in == 4'b0110) || (state_in == 4'b1100);
      if (w_load) begin
        r_rem   <= w_dur;
        r_presc <= '0;
        r_idx   <= w_idx;
      end else if (w_abort) begin
        r_rem   <= 8'h00;
        r_presc <= '0;
      end else if (w_count) begin
        if (w_tick) begin
          r_presc <= '0;
          r_rem   <= w_rem_dec;
        end else begin
          r_presc <= r_presc + PreW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_step_timer.sv
// Directed bench for step_timer with TICK_DIV=4, SHORT_T=3, LONG_T=12; the step-advance
// loop plays the part of the selection FSM.
module tb_step_timer;

  logic       clk;
  logic       rst;
  logic [3:0] state_in;
  logic       pause;
  logic       step_done;
  logic [7:0] rem_bcd;
  logic [1:0] step_idx;
  logic       busy;
  logic       cycle_done;

  int n_checks = 0;
  int n_fail   = 0;

  step_timer #(
    .TICK_DIV(4),
    .SHORT_T (3),
    .LONG_T  (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .state_in  (state_in),
    .pause     (pause),
    .step_done (step_done),
    .rem_bcd   (rem_bcd),
    .step_idx  (step_idx),
    .busy      (busy),
    .cycle_done(cycle_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      step(1);
      if (step_done) pulses++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rem"}, rem_bcd, 8'h00);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
    chk({tag, "_done"}, 8'(step_done), 8'd0);
    chk({tag, "_idx"}, 8'(step_idx), 8'd0);
    chk({tag, "_cyc"}, 8'(cycle_done), 8'd0);
  endtask

  initial begin
    int pulses;
    int cycles;
    logic [3:0] code;

    rst      = 1'b0;
    state_in = 4'b0000;
    pause    = 1'b0;
    step(2);
    chk_all_zero("reset");
    rst = 1'b1;
    step(2);
    chk("idle_busy", 8'(busy), 8'd0);

    // Short step s0: 03,02,01 every 4 cycles then one step_done
    state_in = 4'b0010;
    step(1);
    chk("s0_busy", 8'(busy), 8'd1);
    chk("s0_rem03", rem_bcd, 8'h03);
    chk("s0_idx", 8'(step_idx), 8'd0);
    step(3);
    chk("s0_rem03_hold", rem_bcd, 8'h03);
    step(1);
    chk("s0_rem02", rem_bcd, 8'h02);
    step(4);
    chk("s0_rem01", rem_bcd, 8'h01);
    step(3);
    chk("s0_pre_done", 8'(step_done), 8'd0);
    step(1);
    chk("s0_rem00", rem_bcd, 8'h00);
    chk("s0_done", 8'(step_done), 8'd1);
    chk("s0_busy_off", 8'(busy), 8'd0);
    step(1);
    chk("s0_done_1cyc", 8'(step_done), 8'd0);

    // Long step l0 from WAIT_ADV: 12,11,10,09 with BCD borrow
    state_in = 4'b1000;
    step(1);
    chk("l0_rem12", rem_bcd, 8'h12);
    chk("l0_busy", 8'(busy), 8'd1);
    step(4);
    chk("l0_rem11", rem_bcd, 8'h11);
    step(4);
    chk("l0_rem10", rem_bcd, 8'h10);
    step(4);
    chk("l0_rem09", rem_bcd, 8'h09);
    step(35);
    chk("l0_rem01", rem_bcd, 8'h01);
    chk("l0_pre_done", 8'(step_done), 8'd0);
    step(1);
    chk("l0_done", 8'(step_done), 8'd1);
    chk("l0_rem00", rem_bcd, 8'h00);
    count_pulses(20, pulses);
    chk("l0_no_repeat", 8'(pulses), 8'd0);
    chk("l0_hold_rem", rem_bcd, 8'h00);

    // Pause 10 cycles at 02 on s1
    state_in = 4'b0011;
    step(1);
    chk("s1_idx", 8'(step_idx), 8'd1);
    chk("s1_rem03", rem_bcd, 8'h03);
    step(4);
    chk("s1_rem02", rem_bcd, 8'h02);
    pause = 1'b1;
    step(10);
    chk("pause_rem02", rem_bcd, 8'h02);
    chk("pause_busy", 8'(busy), 8'd1);
    pause = 1'b0;
    step(7);
    chk("pause_rem01", rem_bcd, 8'h01);
    chk("pause_no_done", 8'(step_done), 8'd0);
    step(1);
    chk("pause_done", 8'(step_done), 8'd1);

    // Abort mid-run: 0011 -> 0000
    state_in = 4'b0000;
    step(2);
    state_in = 4'b0011;
    step(5);
    chk("abort_pre_rem", rem_bcd, 8'h02);
    state_in = 4'b0000;
    step(1);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_rem", rem_bcd, 8'h00);
    count_pulses(10, pulses);
    chk("abort_no_done", 8'(pulses), 8'd0);

    // Restart on step-code change mid-run resets rem and prescaler
    state_in = 4'b0010;
    step(6);
    chk("rs_pre_rem", rem_bcd, 8'h02);
    state_in = 4'b0011;
    step(1);
    chk("rs_rem03", rem_bcd, 8'h03);
    chk("rs_idx", 8'(step_idx), 8'd1);
    chk("rs_busy", 8'(busy), 8'd1);
    step(3);
    chk("rs_rem03_hold", rem_bcd, 8'h03);
    step(1);
    chk("rs_rem02", rem_bcd, 8'h02);

    // Asynchronous reset mid-run, then fresh full count with code still present
    #3;
    rst = 1'b0;
    #1;
    chk_all_zero("areset");
    step(1);
    rst = 1'b1;
    step(1);
    chk("rel_busy", 8'(busy), 8'd1);
    chk("rel_rem03", rem_bcd, 8'h03);
    chk("rel_idx", 8'(step_idx), 8'd1);

    // Closed loop over s0..s3 then sc
    state_in = 4'b0000;
    step(2);
    code     = 4'b0010;
    state_in = code;
    pulses   = 0;
    cycles   = 0;
    while ((code != 4'b0110) && (cycles < 200)) begin
      step(1);
      cycles++;
      if (step_done) begin
        pulses++;
        code     = code + 4'd1;
        state_in = code;
      end
    end
    chk("loop_pulses", 8'(pulses), 8'd4);
    chk("loop_cycles", 8'(cycles), 8'd52);
    chk("loop_cyc_lat", 8'(cycle_done), 8'd0);
    step(1);
    chk("loop_cycle_done", 8'(cycle_done), 8'd1);
    chk("loop_busy", 8'(busy), 8'd0);
    chk("loop_idx", 8'(step_idx), 8'd3);

    state_in = 4'b1100;
    step(1);
    chk("lc_cycle_done", 8'(cycle_done), 8'd1);
    state_in = 4'b1101;
    step(1);
    chk("nonstep_cyc", 8'(cycle_done), 8'd0);
    chk("nonstep_busy", 8'(busy), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/step_timer.md
STEP_TIMER -- requirements
Module: step_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per one-second tick (legal range 2..2^26).
REQ-002 Parameter SHORT_T, default 5, seconds per step in short-machine mode (legal range 1..99).
REQ-003 Parameter LONG_T, default 10, seconds per step in long-machine mode (legal range 1..99).
REQ-004 clk  in  1  single clock; all registers on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 state_in  in  4  state code from the machine-selection FSM: menu=0000, ms=0001, s0..s3=0010..0101, sc=0110, ml=0111, l0..l3=1000..1011, lc=1100.
REQ-007 pause  in  1  high freezes the countdown.
REQ-008 step_done  out  1  one-cycle pulse when the current step expires; drives the selection FSM step-advance input x[2].
REQ-009 rem_bcd  out  8  remaining seconds as two BCD digits, tens in [7:4], ones in [3:0].
REQ-010 step_idx  out  2  index 0..3 of the running step.
REQ-011 busy  out  1  high while counting (RUN state).
REQ-012 cycle_done  out  1  high while state_in is sc or lc.

Function
REQ-013 Step codes: s0..s3 (short, duration SHORT_T) and l0..l3 (long, duration LONG_T); all other codes, including 1101..1111, are non-step.
REQ-014 state_in shall be registered once into prev_code every cycle; a change is prev_code != state_in.
REQ-015 Internal FSM states: IDLE, RUN, WAIT_ADV.
REQ-016 IDLE -> RUN in the cycle state_in holds a step code: load rem_bcd = duration (BCD), prescaler = 0, step_idx = low two bits of (code - base), where base is 0010 for s-codes and 1000 for l-codes.
REQ-017 RUN: prescaler increments each cycle pause is low; at TICK_DIV-1 it wraps to 0 and a tick occurs.
REQ-018 On tick, rem_bcd decrements in BCD (ones 0 borrows: ones=9, tens-1); no binary values A..F shall ever appear in either digit.
REQ-019 On the tick that takes rem_bcd from 01 to 00: step_done = 1 for exactly that next cycle, FSM -> WAIT_ADV.
REQ-020 WAIT_ADV: step_done low, rem_bcd held at 00; on a change to a step code -> reload per REQ-016 and enter RUN; on a change to a non-step code -> IDLE.
REQ-021 step_done shall pulse at most once per step, even if state_in never advances.
REQ-022 RUN with change to a different step code: reload and restart per REQ-016 (no step_done).
REQ-023 RUN with change to a non-step code: abort to IDLE, rem_bcd = 00, no step_done.
REQ-024 pause high: prescaler and rem_bcd hold; pause has no effect in IDLE or WAIT_ADV; a tick and pause in the same cycle: pause wins.
REQ-025 busy = 1 only in RUN; cycle_done is a registered decode of state_in, one cycle latency.
REQ-026 Latency: step code on state_in to busy high is one cycle; final tick to step_done is one cycle.

Reset
REQ-027 While rst is low: FSM = IDLE, prescaler = 0, rem_bcd = 00, step_idx = 0, step_done = 0, busy = 0, cycle_done = 0, prev_code = 0000.
REQ-028 Reset asserted mid-RUN shall clear immediately without a step_done pulse; after release, a step code already present on state_in starts a fresh full-duration count.

Verification (TICK_DIV=4, SHORT_T=3, LONG_T=12)
REQ-029 state_in=0010 from IDLE -> busy 1 cycle later, rem_bcd 03, 02, 01 every 4 cycles, then 00 with a single step_done pulse, busy 0.
REQ-030 state_in=1000 -> rem_bcd 12, 11, 10, 09 (BCD borrow checked), ..., 00, step_done once; state_in held at 1000 for 20 more cycles -> no further step_done.
REQ-031 Closed loop with the selection FSM, short path: s0..s3 each takes 3 ticks, four step_done pulses, then sc -> cycle_done=1, busy=0, step_idx last = 3.
REQ-032 pause high for 10 cycles at rem_bcd=02 -> rem_bcd remains 02; resume -> count completes 10 cycles later than the unpaused run.
REQ-033 Mid-RUN, state_in changes 0011 -> 0000 -> IDLE, rem_bcd 00, no step_done; rst low during RUN -> all outputs 0 in the same cycle (asynchronous).
